// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {HI=remainder, LO=quotient}.
// Optional build macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.

`ifndef EXE_DIV_OP
`define EXE_DIV_OP 8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif

module hilo_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         alucontrol_i,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_ZERO, S_END} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               is_signed;
    logic               req;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               early_out;
    logic [WIDTH:0]     shifted, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_next, quo_next;

    function automatic logic [WIDTH-1:0] fix(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    assign is_signed = (alucontrol_i == `EXE_DIV_OP);
    assign req       = start_i & (is_signed | (alucontrol_i == `EXE_DIVU_OP)) & ~annul_i;
    assign mag_a     = (is_signed & opa_i[WIDTH-1]) ? -opa_i : opa_i;
    assign mag_b     = (is_signed & opb_i[WIDTH-1]) ? -opb_i : opb_i;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (mag_a < mag_b);
`else
    assign early_out = 1'b0;
`endif

    // quo_q starts as the dividend magnitude; its MSB feeds the remainder while
    // quotient bits enter at the LSB, so after WIDTH steps it holds the quotient.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign ge       = shifted[WIDTH] | ~diff[WIDTH];
    assign rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], ge};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    negq_d = is_signed & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                    negr_d = is_signed & opa_i[WIDTH-1];
                    dvs_d  = mag_b;
                    quo_d  = mag_a;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (opb_i == '0) begin
                        state_d = S_ZERO;
                    end else if (early_out) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {fix(is_signed & opa_i[WIDTH-1], mag_a), {WIDTH{1'b0}}};
                    end else begin
                        state_d = S_ON;
                    end
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {fix(negr_q, rem_next), fix(negq_q, quo_next)};
                    end
                end
            end
            S_ZERO: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end
            S_END: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Stall drops in END so the pipeline advances while the result is valid.
    assign stall_o  = (req & ~ready_q) | (state_q == S_ON) | (state_q == S_ZERO);
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed + random bench for hilo_div_unit: scoreboard of expected {hi,lo} results,
// latency and stall checks, annul/reset aborts, back-to-back issue.
module tb_hilo_div_unit;

    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;
    localparam logic [7:0] OP_ADD  = 8'b00100000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  alucontrol_i;
    logic        start_i;
    logic        annul_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = '0;

    always #5 clk = ~clk;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .alucontrol_i(alucontrol_i), .start_i(start_i),
        .annul_i(annul_i), .opa_i(opa_i), .opb_i(opb_i), .result_o(result_o),
        .ready_o(ready_o), .stall_o(stall_o)
    );

    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        if (b == 32'd0) return 64'd0;
        if (op == OP_DIV) begin
            sa = $signed(a);
            sb = $signed(b);
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    function automatic int exp_lat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (op == OP_DIV && a[31]) ? -a : a;
        mb = (op == OP_DIV && b[31]) ? -b : b;
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return (ma == mb) ? 33 : 33;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i      = 1'b1;
        alucontrol_i = op;
        opa_i        = a;
        opb_i        = b;
        #1;
    endtask

    // Called in the cycle where the request is presented; returns in the END cycle.
    task automatic wait_done(input int lat_exp);
        int   lat  = 0;
        logic seen = 1'b0;
        while (lat < 100 && !seen) begin
            step();
            lat++;
            if (lat == 1) begin
                start_i      = 1'b0;
                alucontrol_i = 8'($urandom);
                opa_i        = $urandom;
                opb_i        = $urandom;
                #1;
            end
            if (ready_o === 1'b1) seen = 1'b1;
            else check("stall_busy", 64'(stall_o), 64'd1);
        end
        check("ready_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("latency", 64'(lat), 64'(lat_exp));
            check("stall_end", 64'(stall_o), 64'd0);
            if (exp_q.size() > 0) begin
                last_exp = exp_q.pop_front();
                check("result", result_o, last_exp);
            end else begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_q.push_back(exp);
        drive(op, a, b);
        check("stall_req", 64'(stall_o), 64'd1);
        wait_done(exp_lat(op, a, b));
        step();
        check("ready_pulse", 64'(ready_o), 64'd0);
    endtask

    task automatic count_ready(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (ready_o !== 1'b0) pulses++;
        end
    endtask

    initial begin
        int pulses;
        logic [7:0]  rop;
        logic [31:0] ra, rb;

        resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        alucontrol_i = '0; opa_i = '0; opb_i = '0;
        #12;
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        issue(OP_DIV,  32'd7,         32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
        issue(OP_DIVU, 32'hFFFFFFFF,  32'h00000010, {32'h0000000F, 32'h0FFFFFFF});
        issue(OP_DIV,  32'hFFFFFFF8,  32'd3,        {32'hFFFFFFFE, 32'hFFFFFFFE});
        issue(OP_DIV,  32'h80000000,  32'hFFFFFFFF, {32'h00000000, 32'h80000000});
        issue(OP_DIVU, 32'd3,         32'd5,        {32'h00000003, 32'h00000000});

        // DIVU 5/0 then DIV 9/3 presented in the END cycle: accepted one cycle later.
        exp_q.push_back(64'd0);
        drive(OP_DIVU, 32'd5, 32'd0);
        check("stall_req0", 64'(stall_o), 64'd1);
        wait_done(2);
        exp_q.push_back({32'd0, 32'd3});
        drive(OP_DIV, 32'd9, 32'd3);
        check("stall_end_req", 64'(stall_o), 64'd0);
        step();
        check("b2b_ready_low", 64'(ready_o), 64'd0);
        check("b2b_stall_idle", 64'(stall_o), 64'd1);
        wait_done(33);
        step();
        check("b2b_ready_pulse", 64'(ready_o), 64'd0);

        // Non-divide opcode is ignored.
        drive(OP_ADD, 32'd1, 32'd2);
        check("add_stall", 64'(stall_o), 64'd0);
        step();
        check("add_ready", 64'(ready_o), 64'd0);
        check("add_stall2", 64'(stall_o), 64'd0);
        start_i = 1'b0;

        // Annul in ON cycle 10.
        drive(OP_DIV, 32'd100, 32'd7);
        step();
        start_i = 1'b0;
        repeat (9) step();
        annul_i = 1'b1;
        step();
        annul_i = 1'b0;
        #1;
        check("annul_stall", 64'(stall_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        count_ready(40, pulses);
        check("annul_no_ready", 64'(pulses), 64'd0);
        check("annul_result", result_o, last_exp);

        // Reset mid-division.
        drive(OP_DIV, 32'd100, 32'd7);
        step();
        start_i = 1'b0;
        repeat (5) step();
        resetn = 1'b0;
        #1;
        check("mid_rst_result", result_o, 64'd0);
        check("mid_rst_ready", 64'(ready_o), 64'd0);
        check("mid_rst_stall", 64'(stall_o), 64'd0);
        step();
        resetn = 1'b1;
        count_ready(40, pulses);
        check("mid_rst_no_ready", 64'(pulses), 64'd0);
        last_exp = 64'd0;

        issue(OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14});

        for (int i = 0; i < 8; i++) begin
            rop = (i % 2 == 0) ? OP_DIV : OP_DIVU;
            ra  = $urandom;
            rb  = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 5) rb = -32'd13;
            issue(rop, ra, rb, model(rop, ra, rb));
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
